// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and owner encodings shared by the memory arbiter files
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;
   localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals around the arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W/8-1:0] d_wstrb;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;
   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_done,
      output if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_done,
      input  if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// starve_counter: consecutive data grants while fetch waits, saturating at LIMIT
module starve_counter import mem_arb_pkg::*; #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk)
      if (!rstn || clr) cnt <= '0;
      else if (inc && cnt != LIM) cnt <= cnt + 1'b1;
   assign at_limit = cnt == LIM;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data first,
// with fetch forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int STARVE_LIMIT = 4
) (
   input logic            clk,
   input logic            rstn,
   mem_arbiter_if.master  bus
);
   state_t state;
   owner_t owner;
   logic   at_limit, idle, gnt_d, gnt_f;
   assign idle  = state == IDLE;
   assign gnt_d = bus.d_req && !(bus.if_req && at_limit);
   assign gnt_f = bus.if_req && !gnt_d;
   starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (idle && gnt_d && bus.if_req),
      .clr      (idle && (gnt_f || (gnt_d && !bus.if_req))),
      .at_limit (at_limit)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= IDLE;
         owner         <= FETCH;
         bus.mem_req   <= 1'b0;
         bus.if_done   <= 1'b0;
         bus.d_done    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
         bus.if_rdata  <= '0;
         bus.d_rdata   <= '0;
      end else begin
         bus.mem_req <= 1'b0;
         bus.if_done <= 1'b0;
         bus.d_done  <= 1'b0;
         case (state)
            IDLE: if (gnt_d || gnt_f) begin
               state         <= ISSUE;
               owner         <= gnt_d ? DATA : FETCH;
               bus.mem_req   <= 1'b1;
               bus.mem_we    <= gnt_d && bus.d_we;
               bus.mem_addr  <= gnt_d ? bus.d_addr : bus.if_addr;
               bus.mem_wdata <= gnt_d ? bus.d_wdata : '0;
               bus.mem_wstrb <= gnt_d ? bus.d_wstrb : '0;
            end
            ISSUE, WAIT: if (bus.mem_done) begin
               state       <= RESP;
               bus.if_done <= owner == FETCH;
               bus.d_done  <= owner == DATA;
               // stores complete without disturbing the last load value
               if (owner == FETCH) bus.if_rdata <= bus.mem_rdata;
               if (owner == DATA && !bus.mem_we) bus.d_rdata <= bus.mem_rdata;
            end else state <= WAIT;
            RESP: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a transaction-level model
module tb_mem_arbiter;
   localparam int LIMIT = 4;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   int starve = 0;
   logic f_pend = 1'b0, d_pend = 1'b0, rand_raise = 1'b0, gd = 1'b0, exp_we = 1'b0;
   logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0, exp_addr = '0, exp_wdata = '0;
   logic [3:0] exp_wstrb = '0;
   logic [9:0] order = '0;
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      starve = 0;
      f_pend = 1'b0;
      d_pend = 1'b0;
      exp_if_rdata = '0;
      exp_d_rdata = '0;
      exp_addr = '0;
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.d_wstrb = '0;
      bus.mem_rdata = '0;
      bus.mem_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_if_done"}, 32'(bus.if_done), 0);
      check({tag, "_d_done"}, 32'(bus.d_done), 0);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      check({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 0);
      check({tag, "_if_rdata"}, bus.if_rdata, 0);
      check({tag, "_d_rdata"}, bus.d_rdata, 0);
   endtask

   task automatic idle_check(input string tag);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
      check({tag, "_if_done"}, 32'(bus.if_done), 0);
      check({tag, "_d_done"}, 32'(bus.d_done), 0);
      check({tag, "_if_rdata"}, bus.if_rdata, exp_if_rdata);
      check({tag, "_d_rdata"}, bus.d_rdata, exp_d_rdata);
      check({tag, "_mem_addr_held"}, bus.mem_addr, exp_addr);
   endtask

   task automatic raise_f(input logic [31:0] a);
      bus.if_req = 1'b1;
      bus.if_addr = a;
      f_pend = 1'b1;
   endtask

   task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
      bus.d_req = 1'b1;
      bus.d_we = we;
      bus.d_addr = a;
      bus.d_wdata = wd;
      bus.d_wstrb = st;
      d_pend = 1'b1;
   endtask

   // Entered in an IDLE cycle with at least one request up; leaves in the following IDLE cycle.
   task automatic txn(input int n, input logic [31:0] rd);
      gd = bus.d_req && !(bus.if_req && starve == LIMIT);
      starve = (gd && bus.if_req) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      exp_we = gd && bus.d_we;
      exp_addr = gd ? bus.d_addr : bus.if_addr;
      exp_wdata = gd ? bus.d_wdata : '0;
      exp_wstrb = gd ? bus.d_wstrb : '0;
      tick;
      check("issue_mem_req", 32'(bus.mem_req), 1);
      check("issue_mem_we", 32'(bus.mem_we), 32'(exp_we));
      check("issue_mem_addr", bus.mem_addr, exp_addr);
      check("issue_mem_wdata", bus.mem_wdata, exp_wdata);
      check("issue_mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_wstrb));
      for (int i = 0; i <= n; i++) begin
         if (i > 0) check("wait_mem_req", 32'(bus.mem_req), 0);
         check("busy_if_done", 32'(bus.if_done), 0);
         check("busy_d_done", 32'(bus.d_done), 0);
         bus.mem_done = (i == n);
         bus.mem_rdata = (i == n) ? rd : $urandom;
         if (rand_raise && !f_pend && $urandom_range(3) == 0) raise_f($urandom);
         if (rand_raise && !d_pend && $urandom_range(3) == 0)
            raise_d(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
         tick;
      end
      bus.mem_done = 1'b0;
      if (!gd) exp_if_rdata = rd;
      if (gd && !exp_we) exp_d_rdata = rd;
      check("resp_if_done", 32'(bus.if_done), 32'(!gd));
      check("resp_d_done", 32'(bus.d_done), 32'(gd));
      check("resp_mem_req", 32'(bus.mem_req), 0);
      check("resp_if_rdata", bus.if_rdata, exp_if_rdata);
      check("resp_d_rdata", bus.d_rdata, exp_d_rdata);
      if (gd) d_pend = 1'b0;
      else f_pend = 1'b0;
      tick;
      idle_check("post");
   endtask

   initial begin
      model_reset;
      tick;
      tick;
      check_all_zero("reset");
      rstn = 1'b1;
      tick;
      idle_check("idle0");
      // single fetch, one-cycle memory
      raise_f(32'h100);
      txn(1, 32'hDEADBEEF);
      check("fetch_owner", 32'(gd), 0);
      bus.if_req = 1'b0;
      tick;
      idle_check("idle1");
      // simultaneous: store wins, then fetch
      raise_f(32'h180);
      raise_d(1'b1, 32'h200, 32'h12345678, 4'hF);
      txn(1, 32'hAAAA5555);
      check("simul_first_data", 32'(gd), 1);
      bus.d_req = 1'b0;
      txn(1, 32'h0BADF00D);
      check("simul_second_fetch", 32'(gd), 0);
      bus.if_req = 1'b0;
      // zero-latency memory
      raise_d(1'b0, 32'h240, 32'h0, 4'h0);
      txn(0, 32'h13579BDF);
      bus.d_req = 1'b0;
      // stray mem_done in IDLE then a 5-cycle stall
      bus.mem_done = 1'b1;
      bus.mem_rdata = 32'hFFFF0000;
      tick;
      idle_check("stray");
      bus.mem_done = 1'b0;
      tick;
      idle_check("stray2");
      raise_d(1'b0, 32'h280, 32'h0, 4'h0);
      txn(5, 32'h2468ACE0);
      bus.d_req = 1'b0;
      // reset while waiting on memory
      raise_f(32'h300);
      tick;
      check("rst_issue_mem_req", 32'(bus.mem_req), 1);
      tick;
      check("rst_wait_mem_req", 32'(bus.mem_req), 0);
      rstn = 1'b0;
      tick;
      check_all_zero("midrst");
      rstn = 1'b1;
      model_reset;
      bus.mem_done = 1'b1;
      bus.mem_rdata = 32'h77777777;
      tick;
      idle_check("late_done");
      bus.mem_done = 1'b0;
      raise_f(32'h304);
      txn(2, 32'hCAFEF00D);
      check("after_rst_fetch", 32'(gd), 0);
      bus.if_req = 1'b0;
      // starvation guard with both requests held
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      model_reset;
      tick;
      for (int g = 0; g < 10; g++) begin
         if (!f_pend) raise_f($urandom);
         if (!d_pend) raise_d(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
         txn($urandom_range(0, 2), $urandom);
         order[9-g] = gd;
      end
      check("starve_order", 32'(order), 32'(10'b1111011110));
      // randomized traffic
      rand_raise = 1'b1;
      for (int it = 0; it < 300; it++) begin
         if (!f_pend) begin
            if ($urandom_range(1) == 1) raise_f($urandom);
            else bus.if_req = 1'b0;
         end
         if (!d_pend) begin
            if ($urandom_range(1) == 1) raise_d(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
            else bus.d_req = 1'b0;
         end
         if (!f_pend && !d_pend) begin
            tick;
            idle_check("rand_idle");
         end else txn(($urandom_range(7) == 0) ? 5 : $urandom_range(0, 3), $urandom);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
